// File: rtl/rv32_fetch_pkg.sv
// rtl/rv32_fetch_pkg.sv - shared fetch-stage constants and types
package rv32_fetch_pkg;

    localparam logic [31:0] RV32_INSTR_NOP     = 32'h0000_0013;
    localparam logic [6:0]  RV32_OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0]  RV32_OPCODE_BRANCH = 7'b1100011;

    typedef enum logic {
        FETCH_RUN     = 1'b0,
        FETCH_DISCARD = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        taken;
    } fetch_beat_t;

endpackage

// File: rtl/rv32_branch_predictor.sv
// rtl/rv32_branch_predictor.sv - static BTFN next-PC predictor (RV32_BRANCH_PREDICTOR_EN), else pc+4
module rv32_branch_predictor
    import rv32_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output logic [31:0] next_pc,
    output logic        taken
);

`ifdef RV32_BRANCH_PREDICTOR_EN
    logic [31:0] imm_j;
    logic [31:0] imm_b;

    // JAL always taken, backward conditional branches taken, everything else falls through
    always_comb begin
        imm_j   = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        imm_b   = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        next_pc = pc + 32'd4;
        taken   = 1'b0;
        if (instr[6:0] == RV32_OPCODE_JAL) begin
            next_pc = pc + imm_j;
            taken   = 1'b1;
        end else if (instr[6:0] == RV32_OPCODE_BRANCH && instr[31]) begin
            next_pc = pc + imm_b;
            taken   = 1'b1;
        end
    end
`else
    logic unused_instr;

    assign unused_instr = ^instr;
    assign next_pc      = pc + 32'd4;
    assign taken        = 1'b0;
`endif

endmodule

// File: rtl/rv32_fetch.sv
// rtl/rv32_fetch.sv - fetch stage with skid buffer and redirect; predictor via RV32_BRANCH_PREDICTOR_EN
module rv32_fetch
    import rv32_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        branch_mispredicted_in,
    input  logic [31:0] branch_pc_in,
    output logic [31:0] instr_address_out,
    output logic        instr_read_out,
    input  logic        instr_ready_in,
    input  logic [31:0] instr_read_value_in,
    output logic        branch_predicted_taken_out,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  fetch_pc;
    logic [31:0]  pending_pc;
    logic         skid_full;
    fetch_beat_t  skid;
    logic [31:0]  pred_next_pc;
    logic         pred_taken;
    logic         accept;
    logic         stuck;
    logic         keep_beat;

    rv32_branch_predictor u_predictor (
        .pc      (fetch_pc),
        .instr   (instr_read_value_in),
        .next_pc (pred_next_pc),
        .taken   (pred_taken)
    );

    // Request whenever the skid has room; address is simply the fetch PC
    always_comb begin
        instr_read_out    = !reset && !skid_full;
        instr_address_out = fetch_pc;
        accept            = instr_read_out && instr_ready_in;
        stuck             = instr_read_out && !instr_ready_in;
        keep_beat         = accept && (state == FETCH_RUN) && !branch_mispredicted_in;
    end

    // A redirect during an unfinished read must wait for that beat to drain before retargeting
    always_comb begin
        state_next = state;
        if (branch_mispredicted_in) begin
            state_next = stuck ? FETCH_DISCARD : FETCH_RUN;
        end else if (state == FETCH_DISCARD && accept) begin
            state_next = FETCH_RUN;
        end
    end

    // Fetch state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Fetch PC, skid buffer and decode-facing registers
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc                   <= RESET_VECTOR;
            pending_pc                 <= 32'h0;
            skid_full                  <= 1'b0;
            skid                       <= '0;
            pc_out                     <= 32'h0;
            instr_out                  <= RV32_INSTR_NOP;
            branch_predicted_taken_out <= 1'b0;
        end else begin
            if (branch_mispredicted_in) begin
                if (stuck) begin
                    pending_pc <= branch_pc_in;
                end else begin
                    fetch_pc <= branch_pc_in;
                end
            end else if (accept) begin
                fetch_pc <= (state == FETCH_DISCARD) ? pending_pc : pred_next_pc;
            end

            // Unstalled cycles always empty the skid, either by draining or by flushing it
            if (branch_mispredicted_in || !stall_in) begin
                skid_full <= 1'b0;
            end else if (keep_beat) begin
                skid_full <= 1'b1;
                skid      <= '{pc: fetch_pc, instr: instr_read_value_in, taken: pred_taken};
            end

            if (!stall_in) begin
                if (!flush_in && !branch_mispredicted_in && skid_full) begin
                    pc_out                     <= skid.pc;
                    instr_out                  <= skid.instr;
                    branch_predicted_taken_out <= skid.taken;
                end else if (!flush_in && keep_beat) begin
                    pc_out                     <= fetch_pc;
                    instr_out                  <= instr_read_value_in;
                    branch_predicted_taken_out <= pred_taken;
                end else begin
                    instr_out                  <= RV32_INSTR_NOP;
                    branch_predicted_taken_out <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32_fetch.sv
// tb/tb_rv32_fetch.sv - self-checking bench for rv32_fetch (honours RV32_BRANCH_PREDICTOR_EN)
module tb_rv32_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in;
    logic        flush_in;
    logic        branch_mispredicted_in;
    logic [31:0] branch_pc_in;
    logic [31:0] instr_address_out;
    logic        instr_read_out;
    logic        instr_ready_in;
    logic [31:0] instr_read_value_in;
    logic        branch_predicted_taken_out;
    logic [31:0] pc_out;
    logic [31:0] instr_out;

    int errors = 0;
    int checks = 0;

    rv32_fetch dut (
        .clk                        (clk),
        .reset                      (reset),
        .stall_in                   (stall_in),
        .flush_in                   (flush_in),
        .branch_mispredicted_in     (branch_mispredicted_in),
        .branch_pc_in               (branch_pc_in),
        .instr_address_out          (instr_address_out),
        .instr_read_out             (instr_read_out),
        .instr_ready_in             (instr_ready_in),
        .instr_read_value_in        (instr_read_value_in),
        .branch_predicted_taken_out (branch_predicted_taken_out),
        .pc_out                     (pc_out),
        .instr_out                  (instr_out)
    );

    always #5 clk = ~clk;

    // Instruction memory: addi x1,x0,addr[11:0] everywhere, plus a BEQ at 0x40 and a JAL at 0x50
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h40) return 32'hFE00_0CE3;
        if (a == 32'h50) return 32'h0200_006F;
        return 32'h0000_0093 | {a[11:0], 20'h0};
    endfunction

    always_comb instr_read_value_in = mem(instr_address_out);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference prediction from the ISA immediate definitions, with integer offsets
    function automatic void bpred(input logic [31:0] pc, input logic [31:0] ins,
                                  output logic [31:0] nxt, output bit tk);
        int off;
        nxt = pc + 32'd4;
        tk  = 1'b0;
`ifdef RV32_BRANCH_PREDICTOR_EN
        if (ins[6:0] == 7'b1101111) begin
            off = ins[31] ? -(1 << 20) : 0;
            off += int'(ins[19:12]) << 12;
            off += int'(ins[20]) << 11;
            off += int'(ins[30:21]) << 1;
            nxt = pc + 32'(off);
            tk  = 1'b1;
        end else if (ins[6:0] == 7'b1100011 && ins[31]) begin
            off = -4096;
            off += int'(ins[7]) << 11;
            off += int'(ins[30:25]) << 5;
            off += int'(ins[11:8]) << 1;
            nxt = pc + 32'(off);
            tk  = 1'b1;
        end
`endif
    endfunction

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        bit          tk;
    } beat_t;

    beat_t       m_skid[$];
    logic [31:0] m_fpc = 32'h0;
    logic [31:0] m_pend = 32'h0;
    logic [31:0] m_pc_out = 32'h0;
    logic [31:0] m_ins_out = NOP;
    bit          m_tk_out = 1'b0;
    bit          m_pc_valid = 1'b1;
    bit          m_disc = 1'b0;

    // Behavioural model: what decode must see after each clock edge
    always @(posedge clk) begin : model
        beat_t       b;
        beat_t       s;
        logic [31:0] nxt;
        bit          tk;
        bit          req;
        bit          acc;
        bit          show;
        if (reset) begin
            m_fpc = 32'h0;
            m_skid.delete();
            m_disc = 1'b0;
            m_pc_out = 32'h0;
            m_ins_out = NOP;
            m_tk_out = 1'b0;
            m_pc_valid = 1'b1;
        end else begin
            req  = (m_skid.size() == 0);
            acc  = req && instr_ready_in;
            show = 1'b0;
            bpred(m_fpc, mem(m_fpc), nxt, tk);
            b.pc = m_fpc;
            b.ins = mem(m_fpc);
            b.tk = tk;
            if (branch_mispredicted_in) begin
                m_skid.delete();
                if (req && !instr_ready_in) begin
                    m_disc = 1'b1;
                    m_pend = branch_pc_in;
                end else begin
                    m_disc = 1'b0;
                    m_fpc = branch_pc_in;
                end
            end else if (m_disc) begin
                if (acc) begin
                    m_fpc = m_pend;
                    m_disc = 1'b0;
                end
            end else begin
                if (acc) m_fpc = nxt;
                if (stall_in) begin
                    if (acc) m_skid.push_back(b);
                end else if (flush_in) begin
                    m_skid.delete();
                end else if (m_skid.size() != 0) begin
                    s = m_skid.pop_front();
                    m_pc_out = s.pc;
                    m_ins_out = s.ins;
                    m_tk_out = s.tk;
                    m_pc_valid = 1'b1;
                    show = 1'b1;
                end else if (acc) begin
                    m_pc_out = b.pc;
                    m_ins_out = b.ins;
                    m_tk_out = b.tk;
                    m_pc_valid = 1'b1;
                    show = 1'b1;
                end
            end
            if (!stall_in && !show) begin
                m_ins_out = NOP;
                m_tk_out = 1'b0;
                m_pc_valid = 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, sampled after the edge has settled
    always @(posedge clk) begin : compare
        #2;
        chk("read", 32'(instr_read_out), 32'(!reset && m_skid.size() == 0));
        if (!reset) chk("addr", instr_address_out, m_fpc);
        chk("instr", instr_out, m_ins_out);
        chk("taken", 32'(branch_predicted_taken_out), 32'(m_tk_out));
        if (m_pc_valid) chk("pc", pc_out, m_pc_out);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        stall_in = 1'b0;
        flush_in = 1'b0;
        branch_mispredicted_in = 1'b0;
        branch_pc_in = 32'h0;
        instr_ready_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("lit_reset_read", 32'(instr_read_out), 32'd0);
        chk("lit_reset_pc", pc_out, 32'h0);
        chk("lit_reset_instr", instr_out, NOP);

        // Free-running fetch
        reset = 1'b0;
        @(negedge clk);
        chk("lit_run_addr4", instr_address_out, 32'h4);
        chk("lit_run_pc0", pc_out, 32'h0);
        chk("lit_run_instr0", instr_out, 32'h0000_0093);
        @(negedge clk);
        chk("lit_run_addr8", instr_address_out, 32'h8);
        chk("lit_run_instr4", instr_out, 32'h0040_0093);

        // Memory wait on address 8
        instr_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lit_wait_addr", instr_address_out, 32'h8);
            chk("lit_wait_read", 32'(instr_read_out), 32'd1);
            chk("lit_wait_instr", instr_out, NOP);
        end
        instr_ready_in = 1'b1;
        @(negedge clk);
        chk("lit_wait_pc8", pc_out, 32'h8);

        // Stall while the beat at 12 arrives
        stall_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("lit_stall_pc", pc_out, 32'h8);
            chk("lit_stall_read", 32'(instr_read_out), 32'd0);
        end
        stall_in = 1'b0;
        @(negedge clk);
        chk("lit_drain_pc12", pc_out, 32'hC);
        chk("lit_drain_addr16", instr_address_out, 32'h10);
        @(negedge clk);
        chk("lit_resume_pc16", pc_out, 32'h10);
        chk("lit_resume_addr20", instr_address_out, 32'h14);

        // Redirect while the read at 20 is outstanding
        instr_ready_in = 1'b0;
        branch_mispredicted_in = 1'b1;
        branch_pc_in = 32'h100;
        @(negedge clk);
        chk("lit_disc_addr", instr_address_out, 32'h14);
        branch_mispredicted_in = 1'b0;
        @(negedge clk);
        chk("lit_disc_addr2", instr_address_out, 32'h14);
        instr_ready_in = 1'b1;
        @(negedge clk);
        chk("lit_disc_target", instr_address_out, 32'h100);
        chk("lit_disc_nop", instr_out, NOP);
        @(negedge clk);
        chk("lit_redir_pc", pc_out, 32'h100);
        chk("lit_redir_instr", instr_out, 32'h1000_0093);

        // Stall and flush together, then flush alone
        stall_in = 1'b1;
        flush_in = 1'b1;
        @(negedge clk);
        chk("lit_sf_hold", pc_out, 32'h100);
        stall_in = 1'b0;
        @(negedge clk);
        chk("lit_flush_nop", instr_out, NOP);
        flush_in = 1'b0;
        @(negedge clk);
        chk("lit_postflush_pc", pc_out, 32'h108);

        // PC wrap-around
        branch_mispredicted_in = 1'b1;
        branch_pc_in = 32'hFFFF_FFFC;
        @(negedge clk);
        chk("lit_wrap_addr", instr_address_out, 32'hFFFF_FFFC);
        branch_mispredicted_in = 1'b0;
        @(negedge clk);
        chk("lit_wrap_next", instr_address_out, 32'h0);
        chk("lit_wrap_instr", instr_out, 32'hFFC0_0093);

        // Backward branch and forward jump
        branch_mispredicted_in = 1'b1;
        branch_pc_in = 32'h40;
        @(negedge clk);
        branch_mispredicted_in = 1'b0;
        @(negedge clk);
        chk("lit_beq_pc", pc_out, 32'h40);
`ifdef RV32_BRANCH_PREDICTOR_EN
        chk("lit_beq_next", instr_address_out, 32'h38);
        chk("lit_beq_taken", 32'(branch_predicted_taken_out), 32'd1);
`else
        chk("lit_beq_next", instr_address_out, 32'h44);
        chk("lit_beq_taken", 32'(branch_predicted_taken_out), 32'd0);
`endif
        branch_mispredicted_in = 1'b1;
        branch_pc_in = 32'h50;
        @(negedge clk);
        branch_mispredicted_in = 1'b0;
        @(negedge clk);
        chk("lit_jal_pc", pc_out, 32'h50);
`ifdef RV32_BRANCH_PREDICTOR_EN
        chk("lit_jal_next", instr_address_out, 32'h70);
`else
        chk("lit_jal_next", instr_address_out, 32'h54);
`endif

        // Reset in the middle of a handshake
        instr_ready_in = 1'b0;
        reset = 1'b1;
        #1;
        chk("lit_rst_read", 32'(instr_read_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        instr_ready_in = 1'b1;
        @(negedge clk);
        chk("lit_rst_addr", instr_address_out, 32'h4);
        chk("lit_rst_pc", pc_out, 32'h0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
